// File: rtl/lut_and_i8.sv
// 8-bit bitwise AND built from one generic 2-input LUT cell per bit.
// Clock and reset exist only for library interface uniformity; the datapath is purely combinational.

module lut2_cell #(
    parameter logic [3:0] INIT = 4'b1000
) (
    input  logic i0,
    input  logic i1,
    output logic o
);

    // Truth-table mux; select is {i1, i0}
    assign o = INIT[{i1, i0}];

endmodule

module lut_and_i8 #(
    parameter int unsigned WIDTH    = 8,
    parameter logic [3:0]  LUT_INIT = 4'b1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Clock and reset have no function here; fold them into a sink so they stay connected.
    logic unused_ctrl;
    assign unused_ctrl = ^{clock, reset};

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        lut2_cell #(
            .INIT (LUT_INIT)
        ) u_lut (
            .i0 (a[i]),
            .i1 (b[i]),
            .o  (y[i])
        );
    end

endmodule

// File: tb/tb_lut_and_i8.sv
// Directed self-checking bench for lut_and_i8 using immediate assertions.

module tb_lut_and_i8;

    logic       clock;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;

    int vectors;
    int miscompares;

    lut_and_i8 dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .y     (y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] expected);
        vectors++;
        assert (y === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, y, expected);
        end
    endtask

    task automatic apply(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clock);
        a = av;
        b = bv;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] walk;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        a           = 8'd9;
        b           = 8'd15;

        // Output must follow inputs even while reset is held
        repeat (16) @(posedge clock);
        #1;
        check("during_reset", 8'd9);

        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_reset", 8'd9);

        apply(8'hFF, 8'h00); check("ff_and_00", 8'h00);
        apply(8'h00, 8'hFF); check("00_and_ff", 8'h00);
        apply(8'hAA, 8'h55); check("aa_and_55", 8'h00);
        apply(8'hAA, 8'hAA); check("aa_and_aa", 8'hAA);
        apply(8'hFF, 8'hFF); check("ff_and_ff", 8'hFF);
        apply(8'hF0, 8'h3C); check("f0_and_3c", 8'h30);
        apply(8'h5A, 8'hC3); check("5a_and_c3", 8'h42);

        for (int i = 0; i < 8; i++) begin
            walk = 8'h01 << i;
            apply(walk, 8'hFF);
            check($sformatf("walk_a_%0d", i), walk);
        end
        for (int i = 0; i < 8; i++) begin
            walk = 8'h01 << i;
            apply(8'hFF, walk);
            check($sformatf("walk_b_%0d", i), walk);
        end

        // Mid-run reset with inputs changed away from any clock edge
        @(posedge clock);
        #2;
        reset = 1'b1;
        a     = 8'h0F;
        b     = 8'h0B;
        #1;
        check("reset_midrun_immediate", 8'h0B);
        @(posedge clock);
        #1;
        check("reset_midrun_after_edge", 8'h0B);
        #1;
        b = 8'hF6;
        #1;
        check("reset_midrun_complement", 8'h06);
        reset = 1'b0;
        #1;
        check("reset_released", 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
